coco_timer: RTL and testbench
=============================

Name: coco_timer

Overview:
- Memory-mapped programmable countdown timer on the device side of the system bridge. It is a sibling peripheral to the existing timer slots.
- The bridge decodes the CPU's PrAddr/PrWe into this block's Addr/We/WD, returns RD to the CPU, and routes IRQ into one HWInt line.
- Two modes: one-shot with a sticky interrupt, and auto-reload with a one-cycle interrupt pulse.

Parameters:
- none; every width is fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Addr  input  32  byte address from the bridge; only Addr[3:2] is decoded.
- We  input  1  write enable from the bridge, already qualified for this device.
- WD  input  32  write data.
- RD  output  32  read data, combinational from Addr.
- IRQ  output  1  interrupt request to the bridge.

Behaviour:
- Register map (Addr[3:2]):
  - 0 = CTRL: bit 0 Enable, bits [2:1] Mode, bit 3 IM (interrupt mask); bits [31:4] read as 0.
  - 1 = PRESET: 32-bit read/write.
  - 2 = COUNT: read-only; writes are ignored.
  - 3 = reserved: reads 0, writes ignored.
- Reset (reset==0, asynchronous): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so IRQ=0.
- Writes:
  - A write takes effect at the clock edge where We=1.
  - CTRL write stores WD[3:0] and clears irq_flag.
  - PRESET write stores WD; a count already in progress is unaffected until the next LOAD.
- IRQ = CTRL.IM & irq_flag (combinational).
- Mode 0 = one-shot. Mode 1 = auto-reload. Modes 2 and 3 behave as mode 0.
- FSM, evaluated each edge:
  - IDLE: if Enable, go to LOAD; otherwise stay.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - if Enable==0, go to IDLE and hold COUNT;
    - else if COUNT>1, COUNT<=COUNT-1 and stay;
    - else (COUNT is 0 or 1), COUNT<=0, irq_flag<=1, go to INT.
  - INT, mode 0: CTRL.Enable<=0, go to IDLE. irq_flag stays set until a CTRL write.
  - INT, mode 1: irq_flag<=0, go to LOAD. If Enable==0 at this point, irq_flag<=0 and go to IDLE instead.
- Latency: a CTRL write with Enable=1 at edge t and PRESET=N (N>=1) raises irq_flag at edge t+N+2. PRESET=0 behaves like PRESET=1.
- Mode 1 period: N+2 cycles, with IRQ high for exactly 1 cycle per period (when IM=1).
- Simultaneous events:
  - CTRL write in the same edge as the mode-0 INT Enable-clear: the written CTRL value wins, and irq_flag is cleared.
  - CTRL write in the same edge as CNT setting irq_flag: the flag set wins, so the interrupt is not lost.
- IM=0 masks IRQ only; irq_flag still sets and clears normally, so unmasking later exposes a pending mode-0 flag.
- Reset asserted mid-count: immediate return to the reset state, independent of clk.
- RD tracks the current register contents combinationally. A read in the same cycle as a write returns the old value.

Test Plan:
- Reset: hold reset=0 with clk toggling -> RD=0 at every address, IRQ=0. Release reset, write PRESET=5, then CTRL=0x9 (IM=1, mode 0, Enable=1) at edge 0 -> COUNT reads 5 after edge 2, 1 after edge 6, 0 after edge 7. IRQ rises after edge 7. CTRL reads 0x8 after edge 8. IRQ stays high until CTRL is written with 0x8, then falls after that edge.
- Mode 1: PRESET=3, CTRL=0xB -> IRQ is a 1-cycle pulse every 5 cycles, repeating, for at least 3 periods. Writing CTRL=0xA stops the pulses and COUNT freezes.
- Masking: PRESET=2, CTRL=0x1 -> IRQ stays 0 through the expiry. Then write CTRL=0x8 -> IRQ stays 0, because the CTRL write cleared the flag.
- Boundary: PRESET=0 and PRESET=0xFFFFFFFF in mode 1. PRESET=0 gives a 3-cycle period. For 0xFFFFFFFF, COUNT decrements with no wrap; check the first 4 reads: 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD, 0xFFFFFFFC.
- Collisions:
  - PRESET write during CNT -> the current count finishes using the old PRESET, and the next reload uses the new value.
  - COUNT write -> ignored.
  - Address 3 -> reads 0.
  - CTRL write on the same edge as mode-0 expiry -> the written Enable is kept.
- Async reset mid-count: reset pulses low between clock edges while COUNT=3 -> all registers read 0 immediately and IRQ=0.

Source files
------------

// File: rtl/coco_timer.sv
// -----------------------------------------------------------------------------
// coco_timer
//   Memory-mapped 32-bit countdown timer that sits behind the system bridge.
//   It has two modes:
//     - one-shot (mode 0, and also modes 2/3): the interrupt flag stays set
//       until software writes CTRL.
//     - auto-reload (mode 1): the interrupt is a one-cycle pulse, and the
//       count reloads from PRESET after every expiry.
//
// Ports
//   clk    in   1   system clock; all state changes on the rising edge
//   reset  in   1   asynchronous reset, active low
//   Addr   in  32   byte address from the bridge; only Addr[3:2] is decoded
//   We     in   1   write strobe, already qualified for this device
//   WD     in  32   write data
//   RD     out 32   read data, combinational from Addr
//   IRQ    out  1   interrupt request (CTRL.IM & irq flag)
//
// Register map (Addr[3:2])
//   0 CTRL   : [0] Enable, [2:1] Mode, [3] IM; upper bits read as 0
//   1 PRESET : read/write reload value
//   2 COUNT  : read-only current count
//   3 -      : reads 0, writes ignored
// -----------------------------------------------------------------------------
module coco_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        We,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  state_t      state_reg, state_next;
  logic [3:0]  ctrl_reg, ctrl_next;
  logic [31:0] preset_reg, preset_next;
  logic [31:0] count_reg, count_next;
  logic        irq_flag_reg, irq_flag_next;

  // Only Addr[3:2] selects a register; the remaining address bits are
  // intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  logic       enable;
  logic       mode_reload;
  logic       irq_mask;
  logic       expire;

  assign enable      = ctrl_reg[0];
  assign mode_reload = (ctrl_reg[2:1] == 2'b01);
  assign irq_mask    = ctrl_reg[3];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      ctrl_reg     <= 4'd0;
      preset_reg   <= 32'd0;
      count_reg    <= 32'd0;
      irq_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ctrl_reg     <= ctrl_next;
      preset_reg   <= preset_next;
      count_reg    <= count_next;
      irq_flag_reg <= irq_flag_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: the counter FSM first, then bus writes layered on top.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    ctrl_next     = ctrl_reg;
    preset_next   = preset_reg;
    count_next    = count_reg;
    irq_flag_next = irq_flag_reg;
    expire        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (enable) begin
          state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        count_next = preset_reg;
        state_next = S_CNT;
      end

      S_CNT: begin
        if (!enable) begin
          // Count is held so software can read where it stopped.
          state_next = S_IDLE;
        end else if (count_reg > 32'd1) begin
          count_next = count_reg - 32'd1;
        end else begin
          // A count of 0 expires just like a count of 1.
          count_next    = 32'd0;
          irq_flag_next = 1'b1;
          expire        = 1'b1;
          state_next    = S_INT;
        end
      end

      S_INT: begin
        if (mode_reload) begin
          // Auto-reload: the flag lives for exactly one cycle.
          irq_flag_next = 1'b0;
          state_next    = enable ? S_LOAD : S_IDLE;
        end else begin
          // One-shot: disarm, but leave the flag pending for software.
          ctrl_next[0] = 1'b0;
          state_next   = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Bus writes override the FSM's CTRL update (software's Enable wins over
    // the one-shot disarm). The write clears the flag, except on the very
    // edge where an expiry sets it, so that interrupt is not dropped.
    if (We) begin
      case (Addr[3:2])
        ADDR_CTRL: begin
          ctrl_next = WD[3:0];
          if (!expire) begin
            irq_flag_next = 1'b0;
          end
        end
        ADDR_PRESET: begin
          // Only takes effect at the next LOAD; a running count is untouched.
          preset_next = WD;
        end
        default: begin
          // COUNT is read-only and address 3 is reserved.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and interrupt output
  // ---------------------------------------------------------------------------
  always_comb begin
    RD = 32'd0;
    case (Addr[3:2])
      ADDR_CTRL:   RD = {28'd0, ctrl_reg};
      ADDR_PRESET: RD = preset_reg;
      ADDR_COUNT:  RD = count_reg;
      default:     RD = 32'd0;
    endcase
  end

  // Masking only gates the output; the flag itself keeps its own life cycle.
  assign IRQ = irq_mask & irq_flag_reg;

endmodule

// File: tb/tb_coco_timer.sv
// -----------------------------------------------------------------------------
// tb_coco_timer
//   Directed self-checking bench for coco_timer. Each task drives one feature
//   and compares observed values with hand-computed expectations. Edge numbers
//   in the comments count from the edge that writes CTRL (edge 0).
// -----------------------------------------------------------------------------
module tb_coco_timer;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        We;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  int n_checks;
  int n_pass;

  coco_timer dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .We    (We),
    .WD    (WD),
    .RD    (RD),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write; it takes effect on the next rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    WD   = d;
    We   = 1'b1;
    @(posedge clk);
    #1;
    We = 1'b0;
    $display("write addr=0x%h data=0x%h", a, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    Addr = a;
    We   = 1'b0;
    #1;
    d = RD;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0;
    repeat (3) tick();
    for (int a = 0; a < 4; a++) begin
      bus_read(32'(a * 4), v);
      n_checks++;
      if (v !== 32'd0) $display("FAIL reset_rd_addr%0d: got 0x%h expected 0x%h", a, v, 32'd0);
      else n_pass++;
    end
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b expected %b", IRQ, 1'b0);
    else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_oneshot();
    logic [31:0] v;
    bus_write(32'h4, 32'd5);
    bus_write(32'h0, 32'h9);             // edge 0
    tick(); tick();                      // edge 2
    bus_read(32'h8, v);
    n_checks++;
    if (v !== 32'd5) $display("FAIL oneshot_count_e2: got 0x%h expected 0x%h", v, 32'd5);
    else n_pass++;
    repeat (4) tick();                   // edge 6
    bus_read(32'h8, v);
    n_checks++;
    if (v !== 32'd1) $display("FAIL oneshot_count_e6: got 0x%h expected 0x%h", v, 32'd1);
    else n_pass++;
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL oneshot_irq_e6: got %b expected %b", IRQ, 1'b0);
    else n_pass++;
    tick();                              // edge 7
    bus_read(32'h8, v);
    n_checks++;
    if (v !== 32'd0) $display("FAIL oneshot_count_e7: got 0x%h expected 0x%h", v, 32'd0);
    else n_pass++;
    n_checks++;
    if (IRQ !== 1'b1) $display("FAIL oneshot_irq_e7: got %b expected %b", IRQ, 1'b1);
    else n_pass++;
    tick();                              // edge 8
    bus_read(32'h0, v);
    n_checks++;
    if (v !== 32'h8) $display("FAIL oneshot_ctrl_e8: got 0x%h expected 0x%h", v, 32'h8);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (IRQ !== 1'b1) $display("FAIL oneshot_irq_sticky: got %b expected %b", IRQ, 1'b1);
    else n_pass++;
    bus_write(32'h0, 32'h8);
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL oneshot_irq_cleared: got %b expected %b", IRQ, 1'b0);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reload();
    logic [31:0] v;
    logic        exp_irq;
    bus_write(32'h4, 32'd3);
    bus_write(32'h0, 32'hB);             // edge 0
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_irq = (k >= 5) && (((k - 5) % 5) == 0);
      n_checks++;
      if (IRQ !== exp_irq) $display("FAIL reload_irq_e%0d: got %b expected %b", k, IRQ, exp_irq);
      else n_pass++;
    end
    bus_write(32'h0, 32'hA);             // edge 17: LOAD still reloads 3
    bus_read(32'h8, v);
    n_checks++;
    if (v !== 32'd3) $display("FAIL reload_stop_count: got 0x%h expected 0x%h", v, 32'd3);
    else n_pass++;
    repeat (4) tick();
    bus_read(32'h8, v);
    n_checks++;
    if (v !== 32'd3) $display("FAIL reload_frozen_count: got 0x%h expected 0x%h", v, 32'd3);
    else n_pass++;
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL reload_stop_irq: got %b expected %b", IRQ, 1'b0);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mask();
    logic [31:0] v;
    bus_write(32'h4, 32'd2);
    bus_write(32'h0, 32'h1);             // edge 0, expiry at edge 4
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (IRQ !== 1'b0) $display("FAIL mask_irq_e%0d: got %b expected %b", k, IRQ, 1'b0);
      else n_pass++;
    end
    bus_read(32'h0, v);
    n_checks++;
    if (v !== 32'h0) $display("FAIL mask_ctrl_disarmed: got 0x%h expected 0x%h", v, 32'h0);
    else n_pass++;
    bus_write(32'h0, 32'h8);
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL mask_unmask_irq: got %b expected %b", IRQ, 1'b0);
    else n_pass++;
    tick();
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL mask_unmask_irq_later: got %b expected %b", IRQ, 1'b0);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_boundary();
    logic [31:0] v;
    logic        exp_irq;
    logic [31:0] exp_cnt;
    // PRESET=0: 3-cycle period
    bus_write(32'h4, 32'd0);
    bus_write(32'h0, 32'hB);             // edge 0
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_irq = (k >= 3) && ((k % 3) == 0);
      n_checks++;
      if (IRQ !== exp_irq) $display("FAIL bound0_irq_e%0d: got %b expected %b", k, IRQ, exp_irq);
      else n_pass++;
    end
    bus_write(32'h0, 32'h8);
    repeat (3) tick();
    // PRESET=all ones: plain decrement, no wrap
    bus_write(32'h4, 32'hFFFF_FFFF);
    bus_write(32'h0, 32'hB);             // edge 0
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_cnt = 32'hFFFF_FFFF - 32'(k);
      bus_read(32'h8, v);
      n_checks++;
      if (v !== exp_cnt) $display("FAIL boundmax_count_%0d: got 0x%h expected 0x%h", k, v, exp_cnt);
      else n_pass++;
    end
    bus_write(32'h0, 32'h8);
    repeat (2) tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_collisions();
    logic [31:0] v;
    // PRESET rewritten mid-count
    bus_write(32'h4, 32'd4);
    bus_write(32'h0, 32'hB);             // edge 0
    tick(); tick();                      // edge 2
    bus_read(32'h8, v);
    n_checks++;
    if (v !== 32'd4) $display("FAIL coll_count_e2: got 0x%h expected 0x%h", v, 32'd4);
    else n_pass++;
    bus_write(32'h4, 32'd2);             // edge 3
    bus_read(32'h8, v);
    n_checks++;
    if (v !== 32'd3) $display("FAIL coll_count_e3: got 0x%h expected 0x%h", v, 32'd3);
    else n_pass++;
    tick(); tick(); tick();              // edge 6: old preset expires
    n_checks++;
    if (IRQ !== 1'b1) $display("FAIL coll_irq_e6: got %b expected %b", IRQ, 1'b1);
    else n_pass++;
    tick();                              // edge 7
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL coll_irq_e7: got %b expected %b", IRQ, 1'b0);
    else n_pass++;
    tick();                              // edge 8: new preset loaded
    bus_read(32'h8, v);
    n_checks++;
    if (v !== 32'd2) $display("FAIL coll_count_e8: got 0x%h expected 0x%h", v, 32'd2);
    else n_pass++;
    tick();                              // edge 9
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL coll_irq_e9: got %b expected %b", IRQ, 1'b0);
    else n_pass++;
    tick();                              // edge 10
    n_checks++;
    if (IRQ !== 1'b1) $display("FAIL coll_irq_e10: got %b expected %b", IRQ, 1'b1);
    else n_pass++;
    bus_write(32'h0, 32'h8);             // edge 11
    tick(); tick();                      // reload to 2, then stop
    // COUNT write ignored, reserved address
    bus_write(32'h8, 32'h0000_1234);
    bus_read(32'h8, v);
    n_checks++;
    if (v !== 32'd2) $display("FAIL coll_count_write: got 0x%h expected 0x%h", v, 32'd2);
    else n_pass++;
    bus_write(32'hC, 32'hFFFF_FFFF);
    bus_read(32'hC, v);
    n_checks++;
    if (v !== 32'd0) $display("FAIL coll_addr3_read: got 0x%h expected 0x%h", v, 32'd0);
    else n_pass++;
    bus_read(32'h0, v);
    n_checks++;
    if (v !== 32'h8) $display("FAIL coll_addr3_ctrl: got 0x%h expected 0x%h", v, 32'h8);
    else n_pass++;
    bus_read(32'h4, v);
    n_checks++;
    if (v !== 32'd2) $display("FAIL coll_addr3_preset: got 0x%h expected 0x%h", v, 32'd2);
    else n_pass++;
    // CTRL write on the one-shot INT edge, then on the expiry edge
    bus_write(32'h4, 32'd1);
    bus_write(32'h0, 32'h9);             // edge 0
    tick(); tick(); tick();              // edge 3: expiry
    n_checks++;
    if (IRQ !== 1'b1) $display("FAIL coll_int_irq_e3: got %b expected %b", IRQ, 1'b1);
    else n_pass++;
    bus_write(32'h0, 32'h9);             // edge 4: INT disarm vs write
    bus_read(32'h0, v);
    n_checks++;
    if (v !== 32'h9) $display("FAIL coll_int_ctrl_kept: got 0x%h expected 0x%h", v, 32'h9);
    else n_pass++;
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL coll_int_irq_cleared: got %b expected %b", IRQ, 1'b0);
    else n_pass++;
    tick(); tick();                      // edge 6: count=1
    bus_write(32'h0, 32'h9);             // edge 7: expiry vs CTRL write
    n_checks++;
    if (IRQ !== 1'b1) $display("FAIL coll_set_wins_irq: got %b expected %b", IRQ, 1'b1);
    else n_pass++;
    tick();                              // edge 8: one-shot disarm
    bus_read(32'h0, v);
    n_checks++;
    if (v !== 32'h8) $display("FAIL coll_rearm_ctrl_e8: got 0x%h expected 0x%h", v, 32'h8);
    else n_pass++;
    bus_write(32'h0, 32'h8);
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL coll_final_clear: got %b expected %b", IRQ, 1'b0);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    logic [31:0] v;
    bus_write(32'h4, 32'd6);
    bus_write(32'h0, 32'hB);             // edge 0
    repeat (5) tick();                   // edge 5: count=3
    bus_read(32'h8, v);
    n_checks++;
    if (v !== 32'd3) $display("FAIL areset_count_before: got 0x%h expected 0x%h", v, 32'd3);
    else n_pass++;
    #2;
    reset = 1'b0;                        // between clock edges
    for (int a = 0; a < 4; a++) begin
      bus_read(32'(a * 4), v);
      n_checks++;
      if (v !== 32'd0) $display("FAIL areset_rd_addr%0d: got 0x%h expected 0x%h", a, v, 32'd0);
      else n_pass++;
    end
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL areset_irq: got %b expected %b", IRQ, 1'b0);
    else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    We       = 1'b0;
    Addr     = 32'd0;
    WD       = 32'd0;

    test_reset();
    test_oneshot();
    test_reload();
    test_mask();
    test_boundary();
    test_collisions();
    test_async_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
